// File: rtl/dft_pkg.sv
// Shared types and sizing helpers for the DFT sample-FIFO frame sequencer.
package dft_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Default read latency of the sample FIFO and the matching skid depth.
    localparam int unsigned RD_LAT_DEF = 1;
    localparam int unsigned SKID_DEPTH = RD_LAT_DEF + 1;

    // Skid depth needed to cover a FIFO read latency of rd_lat cycles.
    function automatic int unsigned skid_depth(input int unsigned rd_lat);
        return rd_lat + 1;
    endfunction

    // Counter width able to hold 0..2**addr_w inclusive.
    function automatic int unsigned cnt_width(input int unsigned addr_w);
        return $clog2((2 ** addr_w) + 1);
    endfunction

endpackage

// File: rtl/dft_skid_buf.sv
// Small register FIFO used as the output skid buffer.
// Shift-register organisation: the head is always slot 0, so head/valid come
// straight from flops, and an empty buffer presents an all-zero head.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write an entry (caller guarantees no overflow)
//   pop        remove the head entry (caller guarantees non-empty)
//   head       current head entry
//   count      number of stored entries
//   valid      count != 0
module dft_skid_buf
    import dft_pkg::*;
#(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = SKID_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             valid
);

    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] mem_next [DEPTH];
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] wr_idx;

    // Shift on pop, then write the new entry just above the surviving ones.
    always_comb begin
        wr_idx     = count - CNT_W'(pop);
        count_next = count + CNT_W'(push) - CNT_W'(pop);
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            mem_next[i] = pop ? mem[i+1] : mem[i];
        end
        mem_next[DEPTH-1] = pop ? '0 : mem[DEPTH-1];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == CNT_W'(i))) begin
                mem_next[i] = din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            valid <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_next;
            valid <= (count_next != '0);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_next[i];
            end
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/dft_fifo_ctrl.sv
// Frame sequencer for the sample FIFO feeding the DFT core.
// Captures FRAME_LEN ADC sample slots into the FIFO on a trigger, then drains
// the accepted samples over a valid/ready stream with m_last on the final one.
// Optional build macro DFT_FIFO_CTRL_TRIG_SYNC_EN: trig is synchronised and
// edge-detected (one frame per rising edge) instead of sampled as a level.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   trig                           frame start request
//   adc_data, adc_valid            ADC sample stream
//   fifo_wdata, fifo_wr, fifo_full FIFO write side
//   fifo_rdata, fifo_rd, fifo_empty FIFO read side (RD_LAT read latency)
//   m_data, m_valid, m_ready, m_last  output stream to the DFT core
//   busy, done, ovf                status
module dft_fifo_ctrl
    import dft_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned RD_LAT    = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              fifo_wr,
    input  logic              fifo_full,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd,
    input  logic              fifo_empty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int unsigned CW  = cnt_width(ADDR_W);
    localparam int unsigned SD  = skid_depth(RD_LAT);
    localparam int unsigned SCW = $clog2(SD + 1);
    localparam int unsigned EW  = DATA_W + 1;

    state_t            state, state_next;
    logic [CW-1:0]     sample_cnt, sample_cnt_next;
    logic [CW-1:0]     acc_cnt, acc_cnt_next;
    logic [CW-1:0]     rd_issued, rd_issued_next;
    logic [CW-1:0]     cap_cnt, cap_cnt_next;
    logic [RD_LAT-1:0] rd_pipe, rd_pipe_next;
    logic [DATA_W-1:0] fifo_wdata_next;
    logic              fifo_wr_next, done_next, busy_next, ovf_next;
    logic              start;
    logic              rd_c, push_c, pop_c, tag_c;
    logic [CW-1:0]     outstanding_c, credit_c;
    logic [EW-1:0]     head;
    logic [SCW-1:0]    skid_cnt;

`ifdef DFT_FIFO_CTRL_TRIG_SYNC_EN
    // 2-FF synchroniser, rising-edge detect, registered start pulse.
    logic [2:0] trig_sync;
    logic       trig_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_sync  <= '0;
            trig_pulse <= 1'b0;
        end else begin
            trig_sync  <= {trig_sync[1:0], trig};
            trig_pulse <= trig_sync[1] & ~trig_sync[2];
        end
    end

    assign start = trig_pulse;
`else
    assign start = trig;
`endif

    // Read credits: reads in flight plus skid entries that survive this cycle.
    always_comb begin
        outstanding_c = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            outstanding_c = outstanding_c + CW'(rd_pipe[i]);
        end
        credit_c = outstanding_c + CW'(skid_cnt) - CW'(pop_c);
    end

    // fifo_rd must react to this cycle's fifo_empty, so it is combinational.
    assign rd_c = (state == DRAIN) && !fifo_empty && (rd_issued < acc_cnt)
                  && (credit_c < CW'(SD));
    assign fifo_rd = rd_c;

    assign push_c = rd_pipe[RD_LAT-1];
    assign pop_c  = m_valid & m_ready;
    assign tag_c  = (cap_cnt == acc_cnt - CW'(1));

    always_comb begin
        rd_pipe_next[0] = rd_c;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            rd_pipe_next[i] = rd_pipe[i-1];
        end
    end

    dft_skid_buf #(
        .WIDTH (EW),
        .DEPTH (SD)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   ({tag_c, fifo_rdata}),
        .pop   (pop_c),
        .head  (head),
        .count (skid_cnt),
        .valid (m_valid)
    );

    assign m_data = head[DATA_W-1:0];
    assign m_last = head[DATA_W];

    // Next-state and datapath updates.
    always_comb begin
        state_next      = state;
        sample_cnt_next = sample_cnt;
        acc_cnt_next    = acc_cnt;
        rd_issued_next  = rd_issued + CW'(rd_c);
        cap_cnt_next    = cap_cnt + CW'(push_c);
        fifo_wdata_next = fifo_wdata;
        fifo_wr_next    = 1'b0;
        done_next       = 1'b0;
        ovf_next        = ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next      = CAPTURE;
                    ovf_next        = 1'b0;
                    sample_cnt_next = '0;
                    acc_cnt_next    = '0;
                    rd_issued_next  = '0;
                    cap_cnt_next    = '0;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    sample_cnt_next = sample_cnt + CW'(1);
                    if (!fifo_full) begin
                        fifo_wdata_next = adc_data;
                        fifo_wr_next    = 1'b1;
                        acc_cnt_next    = acc_cnt + CW'(1);
                    end else begin
                        ovf_next = 1'b1;
                    end
                    // Dropped samples still use a slot: frame span is fixed.
                    if (sample_cnt == CW'(FRAME_LEN - 1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (acc_cnt == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (pop_c && m_last) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            acc_cnt    <= '0;
            rd_issued  <= '0;
            cap_cnt    <= '0;
            rd_pipe    <= '0;
            fifo_wdata <= '0;
            fifo_wr    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_next;
            sample_cnt <= sample_cnt_next;
            acc_cnt    <= acc_cnt_next;
            rd_issued  <= rd_issued_next;
            cap_cnt    <= cap_cnt_next;
            rd_pipe    <= rd_pipe_next;
            fifo_wdata <= fifo_wdata_next;
            fifo_wr    <= fifo_wr_next;
            done       <= done_next;
            busy       <= busy_next;
            ovf        <= ovf_next;
        end
    end

endmodule
